uart_rx_deframer: RTL and testbench

//  Receive-side UART deframer: consumes the serial rx line, oversamples it, strips start/parity/stop bits.

---
 rtl/uart_rx_deframer_pkg.sv | 26 ++
 rtl/uart_rx_deframer_if.sv | 37 +++
 rtl/uart_rx_deframer_baud_tick.sv | 36 +++
 rtl/uart_rx_deframer.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and constants for the UART receive path.
// Contents:
//   uart_rx_state_e  - deframer FSM states
//   PARITY_MODE_*    - parity sense encodings (value the XOR of data+parity must equal)
//   MAX_DATA_BITS    - widest payload the deframer supports
//   odd_parity()     - reduction XOR helper, 1 when the input has an odd number of ones
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 8;

  function automatic logic odd_parity(input logic [MAX_DATA_BITS-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART deframer and the host-side consumer.
// Signals:
//   rx_data    - received byte, valid while rx_valid is high
//   rx_valid   - a byte is being held for the consumer
//   rx_ready   - consumer accepts on rx_valid && rx_ready
//   parity_err - parity mismatch on the held byte
//   frame_err  - a stop bit of the held byte was sampled low
// Modports: master = deframer side, slave = consumer side.
interface uart_rx_deframer_if
  import uart_rx_deframer_pkg::*;
#(
  parameter int DATA_BITS = MAX_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_deframer_baud_tick.sv
// Oversample tick generator shared by the UART receive and transmit paths.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   baud_div - tick every (baud_div+1) clk cycles; 0 gives a tick every cycle
//   restart  - forces the counter back to 0 so the following ticks are phase-aligned
//   tick     - high for one clk when the counter equals baud_div
module uart_baud_tick
  import uart_rx_deframer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;

  assign tick = (count_q == baud_div);

  // Restart wins over the wrap so the first tick after a start edge lands a full
  // (baud_div+1) period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (restart || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Receive-side UART deframer: synchronises the serial rx line, oversamples it,
// strips start/parity/stop bits and holds each byte for the consumer.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   baud_div   - oversample tick every (baud_div+1) clk cycles
//   rx         - asynchronous serial input, idle high, LSB first
//   rx_bus     - byte handshake (data, valid, ready, parity_err, frame_err)
//   overrun    - one-clk pulse when a frame completes while a byte is still held
//   busy       - FSM is not idle
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               rx,
  uart_rx_deframer_if.master rx_bus,
  output logic               overrun,
  output logic               busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] HALF_TICK = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_TICK = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic           PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  logic rx_meta, rx_s, rx_s_d;
  logic tick, restart, complete;

  uart_rx_state_e       state_q, state_d;
  logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_out_q, ferr_out_q, overrun_q;

  // Synchroniser and edge history reset to the idle line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .restart  (restart),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  // Sample counter counts ticks since the last sample point. START waits half a
  // bit to reach the start-bit centre; every later sample is one full bit on.
  // Only a falling edge arms a frame, so a line stuck low after a break waits.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    restart      = 1'b0;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s_d && !rx_s) begin
          restart      = 1'b1;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          perr_d       = 1'b0;
          ferr_d       = 1'b0;
          state_d      = START;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt_q == HALF_TICK) begin
            sample_cnt_d = '0;
            state_d      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_cnt_q == FULL_TICK) begin
            sample_cnt_d = '0;
            shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (sample_cnt_q == FULL_TICK) begin
            sample_cnt_d = '0;
            perr_d       = (odd_parity(MAX_DATA_BITS'(shift_q)) ^ rx_s) != PAR_MODE;
            state_d      = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (sample_cnt_q == FULL_TICK) begin
            sample_cnt_d = '0;
            if (!rx_s) begin
              ferr_d = 1'b1;
            end
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_d = '0;
              complete  = 1'b1;
              state_d   = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: a completed frame loads when the slot is empty or being
  // emptied in the same cycle, otherwise it is dropped and overrun pulses.
  // ferr_d is used so the final stop sample is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (complete) begin
        if (!valid_q || rx_bus.rx_ready) begin
          data_q     <= shift_q;
          perr_out_q <= perr_q;
          ferr_out_q <= ferr_d;
          valid_q    <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.parity_err = perr_out_q;
  assign rx_bus.frame_err  = ferr_out_q;
  assign overrun           = overrun_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer.
// dut0 is configured 8N1, dut1 is 8E1 (even parity). Expected bytes are pushed to
// a per-DUT queue as frames are driven and popped when the consumer accepts.
module tb_uart_rx_deframer;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        rx0, rx1;
  logic        overrun0, overrun1, busy0, busy1;

  uart_rx_deframer_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_deframer_if #(.DATA_BITS(8)) bus1 ();

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int num_checks = 0;
  int num_fail   = 0;
  int dlv0 = 0, dlv1 = 0, ovr0 = 0, ovr1 = 0;
  int run0 = 0, max_run0 = 0;

  uart_rx_deframer #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DIV_W(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx(rx0),
    .rx_bus(bus0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_deframer #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DIV_W(16)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx(rx1),
    .rx_bus(bus1), .overrun(overrun1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Consumer-side monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus0.rx_valid) run0 = run0 + 1; else run0 = 0;
      if (run0 > max_run0) max_run0 = run0;
      if (overrun0) ovr0++;
      if (bus0.rx_valid && bus0.rx_ready) begin
        dlv0++;
        checkOutput("sb0_has_entry", 32'(exp_q0.size() != 0), 1);
        if (exp_q0.size() != 0) begin
          e = exp_q0.pop_front();
          checkOutput("dut0_rx_data", 32'(bus0.rx_data), 32'(e.data));
          checkOutput("dut0_parity_err", 32'(bus0.parity_err), 32'(e.perr));
          checkOutput("dut0_frame_err", 32'(bus0.frame_err), 32'(e.ferr));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (overrun1) ovr1++;
      if (bus1.rx_valid && bus1.rx_ready) begin
        dlv1++;
        checkOutput("sb1_has_entry", 32'(exp_q1.size() != 0), 1);
        if (exp_q1.size() != 0) begin
          e = exp_q1.pop_front();
          checkOutput("dut1_rx_data", 32'(bus1.rx_data), 32'(e.data));
          checkOutput("dut1_parity_err", 32'(bus1.parity_err), 32'(e.perr));
          checkOutput("dut1_frame_err", 32'(bus1.frame_err), 32'(e.ferr));
        end
      end
    end
  end

  task automatic holdLine(input int sel, input logic lvl, input int cycles);
    if (sel == 0) rx0 = lvl; else rx1 = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Drives one full frame (start, 8 data LSB first, parity on dut1, one stop, one idle bit).
  // When deliver is set the expected result is pushed before the frame goes out.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic par_bit,
                               input logic stop_lvl, input bit deliver);
    int   bt;
    exp_t e;
    bt     = 16 * (int'(baud_div) + 1);
    e.data = data;
    e.perr = (sel == 1) ? ((^data) ^ par_bit) : 1'b0;
    e.ferr = ~stop_lvl;
    if (deliver) begin
      if (sel == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    holdLine(sel, 1'b0, bt);
    for (int i = 0; i < 8; i++) holdLine(sel, data[i], bt);
    if (sel == 1) holdLine(sel, par_bit, bt);
    holdLine(sel, stop_lvl, bt);
    holdLine(sel, 1'b1, bt);
  endtask

  initial begin
    int         d0;
    logic [7:0] rb;
    logic       rp;

    rst_n         = 1'b0;
    baud_div      = 16'd0;
    rx0           = 1'b1;
    rx1           = 1'b1;
    bus0.rx_ready = 1'b1;
    bus1.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(bus0.rx_valid), 0);
    checkOutput("reset_busy", 32'(busy0), 0);
    checkOutput("reset_overrun", 32'(overrun0), 0);
    checkOutput("reset_data", 32'(bus0.rx_data), 0);
    rst_n = 1'b1;
    holdLine(0, 1'b1, 20);

    $display("[TB] basic 8N1 frame 0xA5");
    max_run0 = 0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1);
    checkOutput("a5_valid_width", 32'(max_run0), 1);
    checkOutput("a5_no_overrun", 32'(ovr0), 0);

    $display("[TB] even parity on dut1");
    applyStimulus(1, 8'h07, 1'b0, 1'b1, 1);
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      applyStimulus(1, rb, rp, 1'b1, 1);
      applyStimulus(0, rb ^ 8'h5A, 1'b0, 1'b1, 1);
    end

    $display("[TB] false start");
    d0 = dlv0;
    holdLine(0, 1'b0, 6);
    checkOutput("false_start_busy", 32'(busy0), 1);
    holdLine(0, 1'b1, 40);
    checkOutput("false_start_idle", 32'(busy0), 0);
    checkOutput("false_start_no_byte", 32'(dlv0 - d0), 0);

    $display("[TB] overrun with consumer stalled");
    bus0.rx_ready = 1'b0;
    applyStimulus(0, 8'h11, 1'b0, 1'b1, 1);
    applyStimulus(0, 8'h22, 1'b0, 1'b1, 0);
    checkOutput("overrun_count", 32'(ovr0), 1);
    checkOutput("overrun_held_valid", 32'(bus0.rx_valid), 1);
    checkOutput("overrun_held_data", 32'(bus0.rx_data), 32'h11);
    d0 = dlv0;
    bus0.rx_ready = 1'b1;
    holdLine(0, 1'b1, 4);
    checkOutput("overrun_single_accept", 32'(dlv0 - d0), 1);
    checkOutput("overrun_valid_drop", 32'(bus0.rx_valid), 0);

    $display("[TB] reset in the middle of a frame");
    holdLine(0, 1'b0, 16);
    holdLine(0, 1'b0, 16);
    holdLine(0, 1'b1, 16);
    checkOutput("pre_reset_busy", 32'(busy0), 1);
    rst_n = 1'b0;
    rx0   = 1'b1;
    #1;
    checkOutput("in_reset_busy", 32'(busy0), 0);
    checkOutput("in_reset_data0", 32'(bus0.rx_data), 0);
    checkOutput("in_reset_data1", 32'(bus1.rx_data), 0);
    checkOutput("in_reset_valid", 32'(bus0.rx_valid), 0);
    holdLine(0, 1'b1, 5);
    rst_n = 1'b1;
    holdLine(0, 1'b1, 40);
    d0 = dlv0;
    applyStimulus(0, 8'hC3, 1'b0, 1'b1, 1);
    checkOutput("post_reset_one_byte", 32'(dlv0 - d0), 1);

    $display("[TB] stop bit low and line break");
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1);
    d0 = dlv0;
    exp_q0.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    holdLine(0, 1'b0, 320);
    checkOutput("break_still_idle", 32'(busy0), 0);
    holdLine(0, 1'b1, 48);
    checkOutput("break_single_delivery", 32'(dlv0 - d0), 1);

    $display("[TB] 0xA5 at baud_div=3");
    baud_div = 16'd3;
    holdLine(0, 1'b1, 8);
    max_run0 = 0;
    d0 = dlv0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1);
    checkOutput("slow_valid_width", 32'(max_run0), 1);
    checkOutput("slow_one_byte", 32'(dlv0 - d0), 1);
    baud_div = 16'd0;
    holdLine(0, 1'b1, 8);

    checkOutput("sb0_drained", 32'(exp_q0.size()), 0);
    checkOutput("sb1_drained", 32'(exp_q1.size()), 0);
    checkOutput("dut1_no_overrun", 32'(ovr1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
